synth_io_harness: RTL and testbench

- Parametrised synthesis I/O harness: drives an arbitrarily wide DUT input bus from one serial pin and folds an arbitrarily wide DUT output bus back onto one serial pin, so that place-and-route keeps all DUT logic and LUT counts can be compared across checker variants.
- Wraps any checker under test in the synths flow. Adds what the fixed-width baseline lacks:
  - explicit frame counting;
  - a held input register, so DUT inputs are stable between loads;
  - a selectable output mode: serial shift-out or parity fold.

---
 rtl/synth_harness_pkg.sv | 14 +
 rtl/harness_shift_in.sv | 57 +++++
 rtl/synth_io_harness.sv | 83 ++++++++
 tb/tb_synth_io_harness.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_harness_pkg.sv
// Shared definitions for the synthesis I/O harness: output mode encodings
// and the parameter sanity check used at elaboration time.
package synth_harness_pkg;

    localparam int OUT_MODE_SHIFT  = 0;
    localparam int OUT_MODE_PARITY = 1;

    // True when the harness parameters describe a buildable configuration.
    function automatic bit harness_params_ok(input int in_w, input int out_w, input int out_mode);
        return (in_w >= 2) && (out_w >= 1) &&
               ((out_mode == OUT_MODE_SHIFT) || (out_mode == OUT_MODE_PARITY));
    endfunction

endpackage

// File: rtl/harness_shift_in.sv
// Serial-to-parallel input side of the harness: a shift register fed MSB-first
// from one pin, a saturating bit counter, and a held copy presented to the DUT.
module harness_shift_in
    import synth_harness_pkg::*;
#(
    parameter int IN_W = 566
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_si,
    input  logic            i_si_valid,
    input  logic            i_load,
    output logic [IN_W-1:0] o_dut_in,
    output logic            o_in_full
);

    localparam int ICNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]   r_sr;
    logic [IN_W-1:0]   r_dut_in;
    logic [ICNT_W-1:0] r_in_cnt;
    logic              w_full;

    assign w_full    = (r_in_cnt == ICNT_W'(IN_W));
    assign o_in_full = w_full;
    assign o_dut_in  = r_dut_in;

    // Shift register: new bits enter at the MSB; keeps moving even once full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_si_valid) begin
            r_sr <= {i_si, r_sr[IN_W-1:1]};
        end
    end

    // Held DUT input: takes the pre-shift register contents on load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dut_in <= '0;
        end else if (i_load) begin
            r_dut_in <= r_sr;
        end
    end

    // Frame counter: restarts on load (counting a same-cycle shift), saturates at IN_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_cnt <= '0;
        end else if (i_load) begin
            r_in_cnt <= i_si_valid ? ICNT_W'(1) : '0;
        end else if (i_si_valid && !w_full) begin
            r_in_cnt <= r_in_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/synth_io_harness.sv
// Synthesis I/O harness: feeds a wide DUT input bus from one serial pin and
// folds a wide DUT output bus back onto one serial pin, either as an LSB-first
// shift-out of a captured word or as a registered XOR parity.
module synth_io_harness
    import synth_harness_pkg::*;
#(
    parameter int IN_W     = 566,
    parameter int OUT_W    = 179,
    parameter int OUT_MODE = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             si,
    input  logic             si_valid,
    input  logic             load,
    output logic [IN_W-1:0]  dut_in,
    output logic             in_full,
    input  logic [OUT_W-1:0] dut_out,
    input  logic             capture,
    output logic             so,
    output logic             so_valid
);

    localparam int OCNT_W = $clog2(OUT_W + 1);

    if (!harness_params_ok(IN_W, OUT_W, OUT_MODE)) begin : g_bad_params
        $error("synth_io_harness: need IN_W >= 2, OUT_W >= 1, OUT_MODE in {0,1}");
    end

    harness_shift_in #(
        .IN_W (IN_W)
    ) u_shift_in (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_si       (si),
        .i_si_valid (si_valid),
        .i_load     (load),
        .o_dut_in   (dut_in),
        .o_in_full  (in_full)
    );

    if (OUT_MODE == OUT_MODE_SHIFT) begin : g_shift_out
        logic [OUT_W-1:0]  r_cap;
        logic [OCNT_W-1:0] r_out_cnt;

        // Capture restarts the stream; otherwise shift LSB-first until the count drains.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_cap     <= '0;
                r_out_cnt <= '0;
            end else if (capture) begin
                r_cap     <= dut_out;
                r_out_cnt <= OCNT_W'(OUT_W);
            end else if (r_out_cnt != '0) begin
                r_cap     <= r_cap >> 1;
                r_out_cnt <= r_out_cnt - 1'b1;
            end
        end

        assign so       = r_cap[0];
        assign so_valid = (r_out_cnt != '0);
    end else begin : g_parity
        logic r_par;
        logic r_par_vld;

        // Parity of the captured word, held until the next capture; valid pulses per capture.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_par     <= 1'b0;
                r_par_vld <= 1'b0;
            end else begin
                r_par_vld <= capture;
                if (capture) begin
                    r_par <= ^dut_out;
                end
            end
        end

        assign so       = r_par;
        assign so_valid = r_par_vld;
    end

endmodule

// File: tb/tb_synth_io_harness.sv
// Bench for synth_io_harness: a directed table for the shift-in/shift-out
// scenarios, hand sequences for parity and asynchronous reset, and random
// traffic checked against a queue-based reference model.
module tb_synth_io_harness;

  localparam int IN_W   = 8;
  localparam int OUT_W0 = 4;
  localparam int OUT_W1 = 179;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              si, si_valid, load;
  logic              capture0, capture1;
  logic [OUT_W0-1:0] dout0;
  logic [OUT_W1-1:0] dout1;
  logic [IN_W-1:0]   din0, din1;
  logic              full0, full1;
  logic              so0, so_valid0, so1, so_valid1;

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  synth_io_harness #(.IN_W(IN_W), .OUT_W(OUT_W0), .OUT_MODE(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .si(si), .si_valid(si_valid), .load(load),
    .dut_in(din0), .in_full(full0), .dut_out(dout0), .capture(capture0),
    .so(so0), .so_valid(so_valid0)
  );

  synth_io_harness #(.IN_W(IN_W), .OUT_W(OUT_W1), .OUT_MODE(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .si(si), .si_valid(si_valid), .load(load),
    .dut_in(din1), .in_full(full1), .dut_out(dout1), .capture(capture1),
    .so(so1), .so_valid(so_valid1)
  );

  // ---------------- reference model ----------------
  bit              hist[$];     // every bit shifted since reset, oldest first
  int              nshift;      // shifts since the last load or reset
  logic [IN_W-1:0] m_din;
  bit              oq[$];       // remaining shift-out bits, next one at front
  bit              m_par, m_pvld;

  function automatic logic [IN_W-1:0] model_sr();
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < IN_W; k++)
      if (k < hist.size()) v[IN_W-1-k] = hist[hist.size()-1-k];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    oq.delete();
    nshift = 0;
    m_din  = '0;
    m_par  = 1'b0;
    m_pvld = 1'b0;
  endtask

  task automatic model_step();
    logic [IN_W-1:0] pre;
    if (!RST_N) begin
      model_reset();
      return;
    end
    pre = model_sr();
    if (load) begin
      m_din  = pre;
      nshift = si_valid ? 1 : 0;
    end else if (si_valid) begin
      nshift++;
    end
    if (si_valid) begin
      hist.push_back(si);
      if (hist.size() > IN_W) void'(hist.pop_front());
    end
    if (capture0) begin
      oq.delete();
      for (int i = 0; i < OUT_W0; i++) oq.push_back(dout0[i]);
    end else if (oq.size() != 0) begin
      void'(oq.pop_front());
    end
    if (capture1) m_par = ^dout1;
    m_pvld = capture1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_din0", din0, m_din);
    chk("m_full0", full0, nshift >= IN_W);
    chk("m_sov0", so_valid0, oq.size() != 0);
    if (oq.size() != 0) chk("m_so0", so0, oq[0]);
    chk("m_din1", din1, m_din);
    chk("m_full1", full1, nshift >= IN_W);
    chk("m_sov1", so_valid1, m_pvld);
    chk("m_so1", so1, m_par);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    si = 0; si_valid = 0; load = 0; capture0 = 0; capture1 = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic              si, sv, ld, cap;
    logic [OUT_W0-1:0] dout;
    logic [IN_W-1:0]   e_din;
    logic              e_full, e_sov, e_so;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic s, input logic v, input logic l, input logic c,
                              input logic [3:0] d, input logic [7:0] ed, input logic ef,
                              input logic ev, input logic es);
    vec_t t;
    t.si = s; t.sv = v; t.ld = l; t.cap = c; t.dout = d;
    t.e_din = ed; t.e_full = ef; t.e_sov = ev; t.e_so = es;
    return t;
  endfunction

  initial begin
    // full frame 1,0,1,1,0,0,1,0 then load
    tbl[0]  = mk(1,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[1]  = mk(0,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[2]  = mk(1,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[3]  = mk(1,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[4]  = mk(0,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[5]  = mk(0,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[6]  = mk(1,1,0,0,4'h0, 8'h00,0,0,0);
    tbl[7]  = mk(0,1,0,0,4'h0, 8'h00,1,0,0);
    tbl[8]  = mk(0,0,1,0,4'h0, 8'h4D,0,0,0);
    // three shifts then load with a same-cycle shift
    tbl[9]  = mk(1,1,0,0,4'h0, 8'h4D,0,0,0);
    tbl[10] = mk(1,1,0,0,4'h0, 8'h4D,0,0,0);
    tbl[11] = mk(0,1,0,0,4'h0, 8'h4D,0,0,0);
    tbl[12] = mk(1,1,1,0,4'h0, 8'h69,0,0,0);
    // seven more shifts: count started at 1, so full on the seventh
    for (int i = 13; i < 19; i++) tbl[i] = mk(0,1,0,0,4'h0, 8'h69,0,0,0);
    tbl[19] = mk(0,1,0,0,4'h0, 8'h69,1,0,0);
    // shift-out of 1011
    tbl[20] = mk(0,0,0,1,4'hB, 8'h69,1,1,1);
    tbl[21] = mk(0,0,0,0,4'h0, 8'h69,1,1,1);
    tbl[22] = mk(0,0,0,0,4'h0, 8'h69,1,1,0);
    tbl[23] = mk(0,0,0,0,4'h0, 8'h69,1,1,1);
    tbl[24] = mk(0,0,0,0,4'h0, 8'h69,1,0,0);
    // recapture of 0110 during the second shift-out cycle
    tbl[25] = mk(0,0,0,1,4'hB, 8'h69,1,1,1);
    tbl[26] = mk(0,0,0,0,4'h0, 8'h69,1,1,1);
    tbl[27] = mk(0,0,0,1,4'h6, 8'h69,1,1,0);
    tbl[28] = mk(0,0,0,0,4'h0, 8'h69,1,1,1);
    tbl[29] = mk(0,0,0,0,4'h0, 8'h69,1,1,1);
    tbl[30] = mk(0,0,0,0,4'h0, 8'h69,1,1,0);
    tbl[31] = mk(0,0,0,0,4'h0, 8'h69,1,0,0);
  end

  // ---------------- main sequence ----------------
  initial begin
    RST_N = 1'b0;
    idle_inputs();
    dout0 = '0;
    dout1 = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_din0", din0, 0);
    chk("rst_full0", full0, 0);
    chk("rst_sov0", so_valid0, 0);
    chk("rst_so0", so0, 0);
    chk("rst_sov1", so_valid1, 0);
    chk("rst_so1", so1, 0);
    RST_N = 1'b1;

    // directed table
    for (int i = 0; i < 32; i++) begin
      si = tbl[i].si; si_valid = tbl[i].sv; load = tbl[i].ld;
      capture0 = tbl[i].cap; dout0 = tbl[i].dout; capture1 = 0;
      step();
      chk($sformatf("tbl%0d_din", i), din0, tbl[i].e_din);
      chk($sformatf("tbl%0d_full", i), full0, tbl[i].e_full);
      chk($sformatf("tbl%0d_sov", i), so_valid0, tbl[i].e_sov);
      if (tbl[i].e_sov) chk($sformatf("tbl%0d_so", i), so0, tbl[i].e_so);
    end
    idle_inputs();

    // parity: single capture of all ones, then back-to-back captures
    dout1 = '1; capture1 = 1;
    step();
    chk("par_so_a", so1, 1);
    chk("par_sov_a", so_valid1, 1);
    capture1 = 0;
    step();
    chk("par_so_hold", so1, 1);
    chk("par_sov_pulse", so_valid1, 0);
    capture1 = 1; dout1 = '1;
    step();
    chk("par_b2b_so1", so1, 1);
    chk("par_b2b_sov1", so_valid1, 1);
    dout1[0] = 1'b0;
    step();
    chk("par_b2b_so2", so1, 0);
    chk("par_b2b_sov2", so_valid1, 1);
    capture1 = 0;
    step();
    chk("par_b2b_so3", so1, 0);
    chk("par_b2b_sov3", so_valid1, 0);
    check_model();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      si       = 1'($urandom_range(0, 1));
      si_valid = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 7) == 0);
      capture0 = ($urandom_range(0, 5) == 0);
      capture1 = ($urandom_range(0, 2) == 0);
      dout0    = 4'($urandom_range(0, 15));
      for (int b = 0; b < OUT_W1; b++) dout1[b] = 1'($urandom_range(0, 1));
      step();
      check_model();
    end

    // asynchronous reset in the middle of a frame and a shift-out
    idle_inputs();
    si = 1; si_valid = 1;
    repeat (5) step();
    load = 1; capture0 = 1; dout0 = 4'hF; capture1 = 1; dout1 = '1;
    step();
    idle_inputs();
    si = 1; si_valid = 1;
    step();
    check_model();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_din0", din0, 0);
    chk("mid_rst_full0", full0, 0);
    chk("mid_rst_sov0", so_valid0, 0);
    chk("mid_rst_so0", so0, 0);
    chk("mid_rst_din1", din1, 0);
    chk("mid_rst_sov1", so_valid1, 0);
    chk("mid_rst_so1", so1, 0);
    step();
    RST_N = 1'b1;
    // first edges after release behave as from reset: count starts at zero
    for (int n = 0; n < 12; n++) begin
      si = 1'($urandom_range(0, 1));
      si_valid = 1;
      load = (n == 10);
      step();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
